rl_fifo_1r1w_ctrl: RTL
======================

Name: rl_fifo_1r1w_ctrl

Overview:
Synchronous FIFO controller that drives an external 1R1W RAM (rl_ram_1r1w_* family) through its write and read ports. It converts the RAM's 1-cycle registered-address read into a first-word-fall-through valid/ready stream using a 2-entry output buffer, with full throughput. It sits directly upstream and downstream of the RAM: it generates waddr/din/we/be/raddr and consumes dout.

Parameters:
ABITS, 10, RAM address bits; RAM depth = 2**ABITS words.
DBITS, 32, data width.
AF_LEVEL, 2**ABITS-2, almost_full_o asserts when count_o >= AF_LEVEL.
AE_LEVEL, 2, almost_empty_o asserts when count_o <= AE_LEVEL.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, synchronous, active-high.
clr_i  in  1  synchronous flush.
wr_valid_i  in  1  push request.
wr_ready_o  out  1  push accepted when wr_valid_i & wr_ready_o.
wr_data_i  in  DBITS  push data.
rd_valid_o  out  1  head word valid.
rd_ready_i  in  1  pop when rd_valid_o & rd_ready_i.
rd_data_o  out  DBITS  head word (registered).
ram_waddr_o  out  ABITS  to RAM waddr_i.
ram_din_o  out  DBITS  to RAM din_i (= wr_data_i).
ram_we_o  out  1  to RAM we_i.
ram_be_o  out  (DBITS+7)/8  to RAM be_i; constant all ones.
ram_raddr_o  out  ABITS  to RAM raddr_i.
ram_dout_i  in  DBITS  from RAM dout_o; valid the cycle after the raddr edge.
count_o  out  ABITS+2  total words held (RAM + in-flight + output buffer).
full_o  out  1  RAM holds 2**ABITS words.
empty_o  out  1  count_o == 0.
almost_full_o  out  1  see AF_LEVEL.
almost_empty_o  out  1  see AE_LEVEL.

Behaviour:
- State: wptr, rptr (ABITS, natural wrap), ram_cnt (0..2**ABITS), inflight (1b), out_occ (0..2), out buffer regs b0 (head), b1.
- push = wr_valid_i & wr_ready_o; pop = rd_valid_o & rd_ready_i.
- wr_ready_o = ~full_r & ~rst_i; full_r is registered (ram_cnt == 2**ABITS). Push while full is ignored, with no pointer or count change.
- ram_we_o = push & ~clr_i; ram_waddr_o = wptr; wptr increments on push.
- fetch = (ram_cnt != 0) & (out_occ + inflight - pop < 2) & ~clr_i. ram_raddr_o = rptr; rptr increments on fetch; inflight <= fetch.
- ram_cnt next = ram_cnt + push - fetch. fetch uses the registered ram_cnt, so a word written at edge N is first fetched in cycle N+1. The RAM never sees read and write to the same address in the same cycle for a live word.
- Capture: when inflight=1, ram_dout_i is written into slot (out_occ - pop): b0 if the result is 0, else b1. On pop, b1 shifts to b0.
- rd_valid_o = (out_occ != 0); rd_data_o = b0.
- Latency: push in cycle 0 into an empty FIFO gives rd_valid_o=1 in cycle 3.
- Steady-state simultaneous push and pop every cycle sustains 1 word/cycle with no bubbles.
- count_o = ram_cnt + inflight + out_occ, registered. Maximum is 2**ABITS+2. empty_o, almost_full_o and almost_empty_o are derived from registered next-state values, with no combinational path from inputs.
- clr_i (priority over push/pop/fetch): next cycle pointers, counts, inflight and out_occ are 0; in-flight RAM data is discarded; RAM contents are untouched.
- Reset (rst_i=1) has the same effect as clr_i. While in reset and in the first cycle after it: wr_ready_o=0 during reset and 1 after; rd_valid_o=0, count_o=0, full_o=0, empty_o=1, almost_full_o=0, almost_empty_o=1, ram_we_o=0, ram_raddr_o=0, ram_waddr_o=0.
- Reset asserted mid-operation takes effect at the next edge regardless of any handshake in progress.

Test Plan:
1. Reset, then push 0xA5A5_0001 in cycle 0 with rd_ready_i=0 -> rd_valid_o=1 and rd_data_o=0xA5A5_0001 in cycle 3; count_o=1; empty_o=0.
2. Push 2**ABITS+2 words (ABITS=4: 18 words, data=index) with rd_ready_i=0 -> full_o=1 after the 18th accepted word, count_o=18, wr_ready_o=0. A 19th push is ignored. Drain yields 0..17 in order.
3. Continuous push and pop every cycle for 1000 cycles, incrementing data -> no rd_valid_o gaps after the initial 3-cycle latency, output sequence exact, count_o constant.
4. Wrap-around with ABITS=2: 50 random push/pop bursts -> output order matches a scoreboard across multiple wptr/rptr wraps; ram_we_o never coincides with ram_raddr_o==ram_waddr_o for an unread word.
5. Assert clr_i with 5 words stored and a fetch in flight -> next cycle count_o=0, rd_valid_o=0, empty_o=1. A subsequent push of 0x1234 emerges alone after 3 cycles.
6. Thresholds with ABITS=4, AF_LEVEL=14, AE_LEVEL=2 -> almost_empty_o drops at count_o=3 and almost_full_o rises at count_o=14. Both flags track count_o on the way down.

Source files
------------

// File: rtl/rl_fifo_1r1w_ctrl.sv
// FIFO controller for an external 1R1W RAM with a registered read address.
// A 2-entry output buffer turns the 1-cycle read latency into a full-rate FWFT stream.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS    = 10,
  parameter int DBITS    = 32,
  parameter int AF_LEVEL = 2**ABITS - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [DBITS-1:0]       wr_data_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [DBITS-1:0]       rd_data_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  input  logic [DBITS-1:0]       ram_dout_i,
  output logic [ABITS+1:0]       count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o
);

  localparam int DEPTH = 2**ABITS;
  localparam logic [ABITS:0]   RAM_FULL = DEPTH[ABITS:0];
  localparam logic [ABITS+1:0] AF_L     = AF_LEVEL[ABITS+1:0];
  localparam logic [ABITS+1:0] AE_L     = AE_LEVEL[ABITS+1:0];
  localparam logic [ABITS-1:0] PTR_ONE  = 1;

  logic [ABITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ABITS:0]   ram_cnt_q, ram_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       out_occ_q, out_occ_d;
  logic [DBITS-1:0] b0_q, b0_d, b1_q, b1_d;
  logic [ABITS+1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             push, pop, fetch;
  logic [2:0]       occ_after_pop;
  logic [1:0]       slot;

  assign wr_ready_o     = ~full_q & ~rst_i;
  assign rd_valid_o     = (out_occ_q != 2'd0);
  assign rd_data_o      = b0_q;
  assign ram_waddr_o    = wptr_q;
  assign ram_din_o      = wr_data_i;
  assign ram_we_o       = push & ~clr_i;
  assign ram_be_o       = '1;
  assign ram_raddr_o    = rptr_q;
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;

  // Fetching only uses the registered RAM count, so a word is never read in the cycle it is written.
  always_comb begin
    push          = wr_valid_i & wr_ready_o;
    pop           = rd_valid_o & rd_ready_i;
    occ_after_pop = {1'b0, out_occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fetch         = (ram_cnt_q != '0) & (occ_after_pop < 3'd2) & ~clr_i & ~rst_i;

    wptr_d     = push  ? wptr_q + PTR_ONE : wptr_q;
    rptr_d     = fetch ? rptr_q + PTR_ONE : rptr_q;
    ram_cnt_d  = ram_cnt_q + (ABITS+1)'(push) - (ABITS+1)'(fetch);
    inflight_d = fetch;
    out_occ_d  = out_occ_q + 2'(inflight_q) - 2'(pop);
    slot       = out_occ_q - 2'(pop);

    b0_d = b0_q;
    b1_d = b1_q;
    if (pop) b0_d = b1_q;
    if (inflight_q) begin
      if (slot == 2'd0) b0_d = ram_dout_i;
      else              b1_d = ram_dout_i;
    end

    if (clr_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      out_occ_d  = 2'd0;
    end

    count_d = (ABITS+2)'(ram_cnt_d) + (ABITS+2)'(inflight_d) + (ABITS+2)'(out_occ_d);
    full_d  = (ram_cnt_d == RAM_FULL);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_L);
    ae_d    = (count_d <= AE_L);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_occ_q  <= 2'd0;
      b0_q       <= '0;
      b1_q       <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      out_occ_q  <= out_occ_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

endmodule
